// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and defaults for the UART loopback transmit buffer.
// Holds the drain FSM encoding and default FIFO geometry.
package uart_tx_fifo_pkg;

  localparam int DEF_DEPTH_LOG2 = 4;
  localparam int DEF_DATA_W     = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } drain_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte FIFO: register array, wrapping pointers, separate count.
// Push on a full FIFO and pop on an empty FIFO are ignored.
module uart_byte_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic                  i_pop,
  output logic [DATA_W-1:0]     o_rdata,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_wr_en;
  logic                  w_rd_en;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_wr_en = i_push && !o_full;
  assign w_rd_en = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      unique case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Receive-to-transmit byte buffer with a busy-throttled drain FSM.
// Define UART_TX_FIFO_OVF_CNT_EN to add the saturating ovf_cnt port.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  recv_done,
  input  logic [DATA_W-1:0]     recv_data,
  input  logic                  tx_busy,
  output logic                  send_en,
  output logic [DATA_W-1:0]     send_data,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  fifo_full,
  output logic                  fifo_empty,
`ifdef UART_TX_FIFO_OVF_CNT_EN
  output logic [15:0]           ovf_cnt,
`endif
  output logic                  overflow
);

  drain_state_t        r_state;
  drain_state_t        w_next;
  logic                r_send_en;
  logic [DATA_W-1:0]   r_send_data;
  logic                r_ovf;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_drop;

  // A byte arriving while full is dropped even if LOAD frees a slot now.
  assign w_push = recv_done && !w_full;
  assign w_drop = recv_done && w_full;
  assign w_pop  = (r_state == LOAD);

  uart_byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_fifo (
    .i_clk   (sys_clk),
    .i_rst   (sys_rst),
    .i_push  (w_push),
    .i_wdata (recv_data),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (!w_empty && !tx_busy) w_next = LOAD;
      LOAD:      w_next = START;
      START:     w_next = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) w_next = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= IDLE;
      r_send_en   <= 1'b0;
      r_send_data <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_send_en <= (w_next == START);
      r_ovf     <= w_drop;
      if (w_pop) r_send_data <= w_rdata;
    end
  end

`ifdef UART_TX_FIFO_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      r_ovf_cnt <= '0;
    else if (w_drop && r_ovf_cnt != 16'hFFFF)
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
  end

  assign ovf_cnt = r_ovf_cnt;
`endif

  assign send_en    = r_send_en;
  assign send_data  = r_send_data;
  assign fifo_full  = w_full;
  assign fifo_empty = w_empty;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based model plus directed scenarios.
// Define UART_TX_FIFO_OVF_CNT_EN to also check ovf_cnt.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic       recv_done;
  logic [7:0] recv_data;
  logic       tx_busy = 1'b0;
  logic       send_en;
  logic [7:0] send_data;
  logic [4:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overflow;
`ifdef UART_TX_FIFO_OVF_CNT_EN
  logic [15:0] ovf_cnt;
  int          m_ovf;
`endif

  uart_tx_fifo #(
    .DEPTH_LOG2 (4),
    .DATA_W     (8)
  ) dut (
    .sys_clk    (clk),
    .sys_rst    (sys_rst),
    .recv_done  (recv_done),
    .recv_data  (recv_data),
    .tx_busy    (tx_busy),
    .send_en    (send_en),
    .send_data  (send_data),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
`ifdef UART_TX_FIFO_OVF_CNT_EN
    .ovf_cnt    (ovf_cnt),
`endif
    .overflow   (overflow)
  );

  initial forever #5 clk = ~clk;

  // Transmitter model: manual level, or auto frame of 'frame' cycles.
  int tx_mode  = 0;
  bit man_busy = 1'b0;
  int frame    = 100;
  int busy_cnt = 0;

  always begin
    @(posedge clk);
    #2;
    if (tx_mode == 1) begin
      if (send_en) busy_cnt = frame;
      tx_busy = (busy_cnt != 0);
      if (busy_cnt != 0) busy_cnt--;
    end else begin
      busy_cnt = 0;
      tx_busy  = man_busy;
    end
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state
  logic [7:0] q[$];
  int         mcnt;
  bit         pend_acc, pend_drop;
  bit         have_prev, fall_seen, prev_busy, prev_en;
  bit         bq1, bq2;
  int         cyc, fall_cyc, n_sends;
  logic [7:0] last_data;

  task automatic model_clear();
    q.delete();
    mcnt      = 0;
    pend_acc  = 0;
    pend_drop = 0;
    have_prev = 0;
    fall_seen = 0;
    prev_en   = 0;
    bq1       = 0;
    bq2       = 0;
    last_data = 8'h00;
`ifdef UART_TX_FIFO_OVF_CNT_EN
    m_ovf     = 0;
`endif
  endtask

  task automatic cmp();
    cyc++;
    if (sys_rst) begin
      chk("rst_send_en", 32'(send_en), 0);
      chk("rst_send_data", 32'(send_data), 0);
      chk("rst_count", 32'(fifo_count), 0);
      chk("rst_empty", 32'(fifo_empty), 1);
      chk("rst_full", 32'(fifo_full), 0);
      chk("rst_overflow", 32'(overflow), 0);
`ifdef UART_TX_FIFO_OVF_CNT_EN
      chk("rst_ovf_cnt", 32'(ovf_cnt), 0);
`endif
      model_clear();
      prev_busy = tx_busy;
      return;
    end
    mcnt = mcnt + int'(pend_acc) - int'(send_en);
    chk("count", 32'(fifo_count), 32'(mcnt));
    chk("empty", 32'(fifo_empty), 32'(mcnt == 0));
    chk("full", 32'(fifo_full), 32'(mcnt == DEPTH));
    chk("overflow", 32'(overflow), 32'(pend_drop));
`ifdef UART_TX_FIFO_OVF_CNT_EN
    if (pend_drop && m_ovf < 16'hFFFF) m_ovf++;
    chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
`endif
    if (prev_busy && !tx_busy) begin
      fall_seen = 1;
      fall_cyc  = cyc;
    end
    if (send_en) begin
      n_sends++;
      chk("send_pulse_width", 32'(prev_en), 0);
      chk("busy_before_send", 32'(bq2), 0);
      if (q.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL spurious_send: got send_en=1 required 0 at %0t",
                 $time);
      end else begin
        last_data = q.pop_front();
        chk("send_data", 32'(send_data), 32'(last_data));
      end
      if (have_prev) begin
        chk("fall_before_send", 32'(fall_seen), 1);
        if (fall_seen)
          chk("send_gap_ok", 32'(cyc - fall_cyc >= 3), 1);
      end
      have_prev = 1;
      fall_seen = 0;
    end else begin
      chk("send_data_hold", 32'(send_data), 32'(last_data));
    end
    pend_acc  = recv_done && (mcnt < DEPTH);
    pend_drop = recv_done && (mcnt == DEPTH);
    if (pend_acc) q.push_back(recv_data);
    prev_en   = send_en;
    prev_busy = tx_busy;
    bq2       = bq1;
    bq1       = tx_busy;
  endtask

  task automatic step();
    @(negedge clk);
    cmp();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    recv_done = 1'b1;
    recv_data = d;
    step();
    recv_done = 1'b0;
  endtask

  task automatic do_reset();
    sys_rst   = 1'b1;
    recv_done = 1'b0;
    step();
    step();
    sys_rst = 1'b0;
    step();
  endtask

  task automatic wait_sends(input int target, input int budget);
    int b;
    b = 0;
    while (n_sends < target && b < budget) begin
      step();
      b++;
    end
    chk("send_count", 32'(n_sends), 32'(target));
  endtask

  int base;

  initial begin
    sys_rst   = 1'b1;
    recv_done = 1'b0;
    recv_data = 8'h00;
    cyc       = 0;
    n_sends   = 0;
    fall_cyc  = 0;
    prev_busy = 0;
    model_clear();
    do_reset();

    // Single byte: send_en exactly three cycles after recv_done
    push(8'hA5);
    chk("single_cnt_n1", 32'(fifo_count), 1);
    step();
    chk("single_en_n2", 32'(send_en), 0);
    step();
    chk("single_en_n3", 32'(send_en), 1);
    chk("single_data_n3", 32'(send_data), 32'h00A5);
    chk("single_cnt_n3", 32'(fifo_count), 0);
    step();
    chk("single_en_n4", 32'(send_en), 0);

    // Five back-to-back bytes, 100-cycle frames
    tx_mode = 1;
    frame   = 100;
    do_reset();
    base = n_sends;
    for (int i = 1; i <= 5; i++) push(8'(i));
    wait_sends(base + 5, 1000);
    chk("five_cnt_end", 32'(fifo_count), 0);

    // Overflow with tx_busy stuck high, then drop during LOAD
    tx_mode  = 0;
    man_busy = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
    chk("ovf_full16", 32'(fifo_full), 1);
    chk("ovf_cnt16", 32'(fifo_count), 16);
    chk("ovf_no_pulse16", 32'(overflow), 0);
    push(8'hBB);
    chk("ovf_pulse17", 32'(overflow), 1);
    chk("ovf_cnt17", 32'(fifo_count), 16);
`ifdef UART_TX_FIFO_OVF_CNT_EN
    chk("ovf_counter1", 32'(ovf_cnt), 1);
`endif
    man_busy = 1'b0;
    step();
    push(8'hEE);
    chk("ovf_load_drop", 32'(overflow), 1);
    chk("ovf_load_cnt", 32'(fifo_count), 15);
    chk("ovf_load_en", 32'(send_en), 1);
    chk("ovf_load_data", 32'(send_data), 32'h0040);
`ifdef UART_TX_FIFO_OVF_CNT_EN
    chk("ovf_counter2", 32'(ovf_cnt), 2);
`endif

    // Simultaneous recv_done and LOAD with three entries
    man_busy = 1'b1;
    do_reset();
    push(8'h11);
    push(8'h22);
    push(8'h33);
    step();
    chk("sim_cnt3", 32'(fifo_count), 3);
    man_busy = 1'b0;
    step();
    base = n_sends;
    push(8'h44);
    chk("sim_cnt_hold", 32'(fifo_count), 3);
    chk("sim_en", 32'(send_en), 1);
    chk("sim_data", 32'(send_data), 32'h0011);
    man_busy = 1'b1;
    repeat (3) step();
    man_busy = 1'b0;
    tx_mode  = 1;
    frame    = 4;
    wait_sends(base + 4, 200);
    chk("sim_last", 32'(send_data), 32'h0044);

    // Pointer wrap: forty single bytes through the FIFO
    tx_mode = 1;
    frame   = 2;
    do_reset();
    base = n_sends;
    for (int i = 0; i < 40; i++) begin
      push(8'(i * 7 + 3));
      wait_sends(base + i + 1, 30);
    end
    repeat (5) step();
    chk("wrap_cnt_end", 32'(fifo_count), 0);
    chk("wrap_last", 32'(send_data), 32'(8'(39 * 7 + 3)));

    // Reset while in WAIT_DONE with four bytes queued
    tx_mode = 1;
    frame   = 100;
    do_reset();
    base = n_sends;
    for (int i = 0; i < 5; i++) push(8'(8'hA0 + i));
    wait_sends(base + 1, 20);
    repeat (6) step();
    chk("rstq_cnt4", 32'(fifo_count), 4);
    sys_rst = 1'b1;
    #1;
    chk("rstq_en", 32'(send_en), 0);
    chk("rstq_data", 32'(send_data), 0);
    chk("rstq_cnt", 32'(fifo_count), 0);
    chk("rstq_empty", 32'(fifo_empty), 1);
    chk("rstq_full", 32'(fifo_full), 0);
    step();
    tx_mode  = 0;
    man_busy = 1'b0;
    sys_rst  = 1'b0;
    base     = n_sends;
    repeat (20) step();
    chk("rstq_no_send", 32'(n_sends), 32'(base));
    push(8'h5A);
    wait_sends(base + 1, 10);
    chk("rstq_new_data", 32'(send_data), 32'h005A);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
